// File: rtl/ahb_wait_mem_slave.sv
// AHB-Lite byte-addressed memory slave with programmable wait states, write strobes,
// an address-window error injector, misalignment checking and saturating beat counters.
module ahb_wait_mem_slave #(
  parameter int          DATA_W    = 32,
  parameter int          MEM_DEPTH = 256,
  parameter int          WAIT_W    = 4,
  parameter logic [31:0] ERR_LO    = 32'hFFFF_FFFF,
  parameter logic [31:0] ERR_HI    = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic                  HREADYIN,
  input  logic [DATA_W-1:0]     HWDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic [WAIT_W-1:0]     WAIT_IN,
  output logic [DATA_W-1:0]     HRDATA,
  output logic                  HREADYOUT,
  output logic [1:0]            HRESP,
  output logic [CNT_W-1:0]      RD_CNT,
  output logic [CNT_W-1:0]      WR_CNT
);

  localparam int          NB       = DATA_W / 8;
  localparam int          NBL      = $clog2(NB);
  localparam int          AW       = $clog2(MEM_DEPTH);
  localparam bit          WIN_EN   = (ERR_LO <= ERR_HI);
  localparam logic [31:0] WIN_SPAN = ERR_HI - ERR_LO;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  logic [7:0] mem [MEM_DEPTH];

  state_e              state_q, state_d;
  logic [AW-1:0]       off_q, off_d;
  logic                write_q, write_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;

  logic                accept;
  logic                acc_err;
  logic [31:0]         acc_off32;
  logic [AW-1:0]       base;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_beat;
  logic                wr_beat;

  // Only the in-memory offset matters; upper address bits alias onto the same bytes.
  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:AW], HTRANS[0]};

  assign accept    = HSEL && HREADYIN && HTRANS[1];
  assign acc_off32 = 32'(HADDR[AW-1:0]);

  // Unsigned span test covers [ERR_LO, ERR_HI] without wrap-around issues at either end.
  always_comb begin
    acc_err = 1'b0;
    if (WIN_EN && ((acc_off32 - ERR_LO) <= WIN_SPAN))
      acc_err = 1'b1;
    if (HSIZE > 3'(NBL))
      acc_err = 1'b1;
    if ((acc_off32 & ((32'd1 << HSIZE) - 32'd1)) != 32'd0)
      acc_err = 1'b1;
  end

  assign base    = off_q & ~AW'(NB - 1);
  assign rd_beat = (state_q == ST_DATA) && !write_q;
  assign wr_beat = (state_q == ST_DATA) && write_q;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++)
      rd_word[8*i +: 8] = mem[base + AW'(i)];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    write_d    = write_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q <= WAIT_W'(1))
          state_d = ST_DATA;
        else
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all present HREADYOUT=1, so a new address phase may start here.
        state_d = ST_IDLE;
        if (accept) begin
          off_d   = HADDR[AW-1:0];
          write_d = HWRITE;
          if (acc_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_IN == '0) begin
            state_d = ST_DATA;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_IN;
          end
        end
      end
    endcase
  end

  always_comb begin
    hrdata_d = hrdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_beat) begin
      hrdata_d = rd_word;
      if (rd_cnt_q != '1)
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (wr_beat && (wr_cnt_q != '1))
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      off_q      <= '0;
      write_q    <= 1'b0;
      wait_cnt_q <= '0;
      hrdata_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      write_q    <= write_d;
      wait_cnt_q <= wait_cnt_d;
      hrdata_q   <= hrdata_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; contents survive HRESET
  // and are preloaded hierarchically, and a reset port would block RAM inference.
  always_ff @(posedge HCLK) begin
    if (wr_beat) begin
      for (int i = 0; i < NB; i++)
        if (WSTRB[i])
          mem[base + AW'(i)] <= HWDATA[8*i +: 8];
    end
  end

  // Read data is live during a read DATA cycle so a write completing just before is visible.
  assign HRDATA    = rd_beat ? rd_word : hrdata_q;
  assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP     = {1'b0, (state_q == ST_ERR1) || (state_q == ST_ERR2)};
  assign RD_CNT    = rd_cnt_q;
  assign WR_CNT    = wr_cnt_q;

endmodule

// File: tb/tb_ahb_wait_mem_slave.sv
// Scoreboard bench for ahb_wait_mem_slave: a bus engine issues queued beats, a byte-level
// memory model predicts each response at acceptance, and completions are compared in order.
module tb_ahb_wait_mem_slave;

  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 256;
  localparam int WAIT_W = 4;
  localparam int CNT_W  = 5;
  localparam int LIMIT  = 2000;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic              HSEL = 1'b0;
  logic [31:0]       HADDR = '0;
  logic [1:0]        HTRANS = 2'b00;
  logic              HWRITE = 1'b0;
  logic [2:0]        HSIZE = 3'd2;
  logic              HREADYIN;
  logic [DATA_W-1:0] HWDATA = '0;
  logic [NB-1:0]     WSTRB = '0;
  logic [WAIT_W-1:0] WAIT_IN = '0;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;
  logic [1:0]        HRESP;
  logic [CNT_W-1:0]  RD_CNT;
  logic [CNT_W-1:0]  WR_CNT;

  assign HREADYIN = HREADYOUT;

  ahb_wait_mem_slave #(
    .DATA_W(DATA_W), .MEM_DEPTH(DEPTH), .WAIT_W(WAIT_W),
    .ERR_LO(32'h40), .ERR_HI(32'h4F), .CNT_W(CNT_W)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADYIN(HREADYIN), .HWDATA(HWDATA),
    .WSTRB(WSTRB), .WAIT_IN(WAIT_IN), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .RD_CNT(RD_CNT), .WR_CNT(WR_CNT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    bit          write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  wait_n;
  } beat_t;

  typedef struct {
    bit          is_read;
    bit          err;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  beat_t            stim_q[$];
  exp_t             sb_q[$];
  logic [7:0]       model_mem [DEPTH];
  logic [CNT_W-1:0] exp_rd = '0;
  logic [CNT_W-1:0] exp_wr = '0;
  logic [31:0]      last_rdata = '0;
  int               n_tests = 0;
  int               n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Predicts the slave's response and applies its side effects to the model.
  function automatic exp_t model_beat(beat_t b);
    exp_t e;
    int   off  = int'(b.addr % DEPTH);
    int   base = off & ~(NB - 1);
    e.is_read = !b.write;
    e.err     = (off >= 'h40 && off <= 'h4F) || (b.size > 3'd2) ||
                ((off % (1 << b.size)) != 0);
    e.waits   = e.err ? 1 : int'(b.wait_n);
    e.rdata   = '0;
    if (!e.err) begin
      if (b.write) begin
        for (int i = 0; i < NB; i++)
          if (b.wstrb[i]) model_mem[base + i] = b.wdata[8*i +: 8];
        if (exp_wr != CNT_MAX) exp_wr = exp_wr + 1'b1;
      end else begin
        for (int i = 0; i < NB; i++)
          e.rdata[8*i +: 8] = model_mem[base + i];
        if (exp_rd != CNT_MAX) exp_rd = exp_rd + 1'b1;
      end
    end
    return e;
  endfunction

  task automatic push_beat(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [3:0] wait_n);
    beat_t b;
    b.addr = addr; b.write = wr; b.size = size;
    b.wdata = wdata; b.wstrb = wstrb; b.wait_n = wait_n;
    stim_q.push_back(b);
  endtask

  // Pipelined master: drives on negedges, address of the next beat overlaps the current data phase.
  task automatic run_bus(input string name);
    bit          busy = 1'b0;
    bit          first = 1'b1;
    bit          ready;
    int          waits = 0;
    int          cyc = 0;
    logic [31:0] cur_wdata = '0;
    logic [3:0]  cur_wstrb = '0;
    beat_t       b;
    exp_t        e;
    while ((stim_q.size() > 0 || busy) && cyc < LIMIT) begin
      if (stim_q.size() > 0) begin
        HSEL    = 1'b1;
        HTRANS  = first ? 2'b10 : 2'b11;
        HADDR   = stim_q[0].addr;
        HWRITE  = stim_q[0].write;
        HSIZE   = stim_q[0].size;
        WAIT_IN = stim_q[0].wait_n;
      end else begin
        HSEL   = 1'b0;
        HTRANS = 2'b00;
      end
      if (busy) begin
        HWDATA = cur_wdata;
        WSTRB  = cur_wstrb;
      end
      #1;
      ready = HREADYOUT;
      if (busy) begin
        if (ready) begin
          e = sb_q.pop_front();
          check($sformatf("%s_resp", name), 64'(HRESP), {63'd0, e.err});
          check($sformatf("%s_waits", name), 64'(waits), 64'(e.waits));
          if (e.is_read && !e.err) begin
            check($sformatf("%s_rdata", name), 64'(HRDATA), 64'(e.rdata));
            last_rdata = e.rdata;
          end
        end else begin
          waits++;
        end
      end
      @(posedge HCLK);
      if (ready) begin
        busy = 1'b0;
        if (stim_q.size() > 0) begin
          b = stim_q.pop_front();
          sb_q.push_back(model_beat(b));
          cur_wdata = b.wdata;
          cur_wstrb = b.wstrb;
          busy  = 1'b1;
          first = 1'b0;
          waits = 0;
        end
      end
      @(negedge HCLK);
      cyc++;
    end
    if (cyc >= LIMIT) check($sformatf("%s_timeout", name), 64'(cyc), 64'(LIMIT - 1));
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    WSTRB  = '0;
    check($sformatf("%s_rd_cnt", name), 64'(RD_CNT), 64'(exp_rd));
    check($sformatf("%s_wr_cnt", name), 64'(WR_CNT), 64'(exp_wr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] keep [4];
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 8'(2 * i);
      dut.mem[i]   = 8'(2 * i);
    end
    repeat (3) @(negedge HCLK);
    check("reset_hready", 64'(HREADYOUT), 64'd1);
    check("reset_hresp", 64'(HRESP), 64'd0);
    check("reset_hrdata", 64'(HRDATA), 64'd0);
    check("reset_rd_cnt", 64'(RD_CNT), 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // T1: zero-wait word read of preloaded data
    push_beat(32'h0, 1'b0, 3'd2, '0, '0, 4'd0);
    run_bus("t1");
    check("t1_const_rdata", 64'(last_rdata), 64'h0604_0200);
    check("t1_const_rd_cnt", 64'(RD_CNT), 64'd1);

    // T2: strobed write with three wait states; read data must hold across it
    push_beat(32'h4, 1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101, 4'd3);
    run_bus("t2");
    check("t2_mem4", 64'(dut.mem[4]), 64'hDD);
    check("t2_mem5", 64'(dut.mem[5]), 64'h0A);
    check("t2_mem6", 64'(dut.mem[6]), 64'hBB);
    check("t2_mem7", 64'(dut.mem[7]), 64'h0E);
    check("t2_hrdata_hold", 64'(HRDATA), 64'h0604_0200);

    // T3: eight pipelined reads wrapping past the top of memory
    for (int k = 0; k < 8; k++)
      push_beat(32'hF0 + 32'(4 * k), 1'b0, 3'd2, '0, '0, 4'd0);
    run_bus("t3");

    // BUSY/IDLE while selected: zero-wait OKAY, nothing counted
    HSEL = 1'b1; HTRANS = 2'b01;
    @(negedge HCLK);
    check("busy_hready", 64'(HREADYOUT), 64'd1);
    check("busy_hresp", 64'(HRESP), 64'd0);
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("idle_hready", 64'(HREADYOUT), 64'd1);
    HSEL = 1'b0;
    check("busy_rd_cnt", 64'(RD_CNT), 64'(exp_rd));

    // T4: error window, misalignment, oversize and window edges
    for (int i = 0; i < 4; i++) keep[i] = dut.mem['h44 + i];
    push_beat(32'h44, 1'b1, 3'd2, 32'h1122_3344, 4'hF, 4'd0);
    push_beat(32'h01, 1'b0, 3'd1, '0, '0, 4'd0);
    push_beat(32'h00, 1'b0, 3'd3, '0, '0, 4'd1);
    push_beat(32'h3C, 1'b0, 3'd2, '0, '0, 4'd0);
    push_beat(32'h40, 1'b0, 3'd0, '0, '0, 4'd0);
    push_beat(32'h4F, 1'b0, 3'd0, '0, '0, 4'd2);
    push_beat(32'h50, 1'b0, 3'd2, '0, '0, 4'd1);
    push_beat(32'h13, 1'b0, 3'd0, '0, '0, 4'd0);
    run_bus("t4");
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_mem%0d", 'h44 + i), 64'(dut.mem['h44 + i]), 64'(keep[i]));

    // T5: reset while the slave is stalling a write
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'd2; WAIT_IN = 4'd5;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
    check("t5_in_wait", 64'(HREADYOUT), 64'd0);
    @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    check("t5_hready", 64'(HREADYOUT), 64'd1);
    check("t5_hresp", 64'(HRESP), 64'd0);
    check("t5_rd_cnt", 64'(RD_CNT), 64'd0);
    check("t5_wr_cnt", 64'(WR_CNT), 64'd0);
    check("t5_hrdata", 64'(HRDATA), 64'd0);
    exp_rd = '0; exp_wr = '0;
    repeat (6) @(negedge HCLK);
    HRESET = 1'b0; WSTRB = '0;
    @(negedge HCLK);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5_mem%0d", 'h20 + i), 64'(dut.mem['h20 + i]), 64'(model_mem['h20 + i]));

    // T6: DMA-style copy of 18 mixed-size beats, destination stalls two cycles; counters saturate
    for (int k = 0; k < 18; k++) begin
      int          sz   = k % 3;
      int          lane = (sz == 0) ? (k % 4) : (sz == 1) ? 2 * (k % 2) : 0;
      logic [31:0] sbase = 32'h50 + 32'(4 * k);
      logic [31:0] word;
      for (int i = 0; i < NB; i++) word[8*i +: 8] = model_mem[sbase + i];
      push_beat(sbase + 32'(lane), 1'b0, 3'(sz), '0, '0, 4'(k % 2));
      push_beat(32'h10A0 + 32'(4 * k + lane), 1'b1, 3'(sz), word,
                4'(((1 << (1 << sz)) - 1) << lane), 4'd2);
    end
    run_bus("t6_copy");
    for (int k = 0; k < 18; k++)
      push_beat(32'hA0 + 32'(4 * k), 1'b0, 3'd2, '0, '0, 4'd0);
    run_bus("t6_check");
    check("t6_rd_sat", 64'(RD_CNT), 64'(CNT_MAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
